q_proj_scheduler: RTL and testbench

Tile-level sequencer for the Q-projection engine. One `start` pulse runs a full projection of `N_ROWS` input token rows against `N_TILES` weight column tiles. For each tile the block:

- opens a timed weight-load window,
- streams the input row indices with back-pressure,
- waits a fixed pipeline drain,
- then advances to the next tile.

It sits between the top-level control FSM and the weight-load window, input-row fetch and accumulator-clear strobes of the projection datapath.

---
 rtl/q_proj_scheduler_if.sv | 32 +++
 rtl/q_proj_scheduler.sv | 128 ++++++++++++
 tb/tb_q_proj_scheduler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_proj_scheduler_if.sv
// Control/strobe bundle between the top-level control FSM, the Q-projection
// tile sequencer and the projection datapath strobes.
interface q_proj_scheduler_if #(
    parameter int N_ROWS  = 4,
    parameter int N_TILES = 2
);
    localparam int XW = (N_ROWS  > 1) ? $clog2(N_ROWS)  : 1;
    localparam int TW = (N_TILES > 1) ? $clog2(N_TILES) : 1;

    logic          start;
    logic          abort;
    logic          out_stall;
    logic          busy;
    logic          w_load_en;
    logic          acc_clr;
    logic          x_valid;
    logic [XW-1:0] x_row;
    logic [TW-1:0] tile_idx;
    logic          done;

    // Controller side: issues jobs and back-pressure, observes strobes.
    modport master (
        output start, abort, out_stall,
        input  busy, w_load_en, acc_clr, x_valid, x_row, tile_idx, done
    );

    // Sequencer side.
    modport slave (
        input  start, abort, out_stall,
        output busy, w_load_en, acc_clr, x_valid, x_row, tile_idx, done
    );
endinterface

// File: rtl/q_proj_scheduler.sv
// Tile-level sequencer for the Q-projection engine. Per tile: timed weight-load
// window, back-pressured row streaming, fixed pipeline drain, then next tile.
module q_proj_scheduler #(
    parameter int N_ROWS       = 4,
    parameter int N_TILES      = 2,
    parameter int LOAD_CYCLES  = 7,
    parameter int DRAIN_CYCLES = 10
) (
    input  logic                clk,
    input  logic                rst,
    q_proj_scheduler_if.slave   bus
);
    localparam int XW   = (N_ROWS  > 1) ? $clog2(N_ROWS)  : 1;
    localparam int TW   = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int CMAX = (LOAD_CYCLES > DRAIN_CYCLES) ? LOAD_CYCLES : DRAIN_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [XW-1:0] ROW_LAST   = XW'(N_ROWS - 1);
    localparam logic [TW-1:0] TILE_LAST  = TW'(N_TILES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [XW-1:0] x_row_q;
    logic [TW-1:0] tile_q;
    logic          acc_clr_q;
    logic          done_q;

    logic          x_valid_d;

    // A row is issued whenever we stream and the datapath is not stalling.
    always_comb begin
        x_valid_d = (state_q == S_STREAM) && !bus.out_stall;
    end

    // Sequencer FSM: phase counter, row/tile indices and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            x_row_q   <= '0;
            tile_q    <= '0;
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            // Abort is checked ahead of the state decode so every busy state
            // shares the same clean return to IDLE without a done pulse.
            if (state_q != S_IDLE && bus.abort) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                x_row_q <= '0;
                tile_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state_q   <= S_LOAD;
                            cnt_q     <= '0;
                            x_row_q   <= '0;
                            tile_q    <= '0;
                            acc_clr_q <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (cnt_q == LOAD_LAST) begin
                            state_q <= S_STREAM;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    S_STREAM: begin
                        if (x_valid_d) begin
                            if (x_row_q == ROW_LAST) begin
                                state_q <= S_DRAIN;
                                x_row_q <= '0;
                                cnt_q   <= '0;
                            end else begin
                                x_row_q <= x_row_q + XW'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (cnt_q == DRAIN_LAST) begin
                            cnt_q <= '0;
                            if (tile_q != TILE_LAST) begin
                                state_q   <= S_LOAD;
                                tile_q    <= tile_q + TW'(1);
                                acc_clr_q <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                tile_q  <= '0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        x_row_q <= '0;
                        tile_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.w_load_en = (state_q == S_LOAD);
    assign bus.acc_clr   = acc_clr_q;
    assign bus.x_valid   = x_valid_d;
    assign bus.x_row     = x_row_q;
    assign bus.tile_idx  = tile_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_q_proj_scheduler.sv
// Self-checking bench for q_proj_scheduler: a default-parameter instance and a
// minimum-parameter instance, checked cycle by cycle against an expected trace.
module tb_q_proj_scheduler;
    localparam int NR   = 4;
    localparam int NT   = 2;
    localparam int LC   = 7;
    localparam int DC   = 10;
    localparam int MAXC = 256;
    localparam logic [20:0] FLAGS_M = 21'h1F0000;
    localparam logic [20:0] ALL_M   = 21'h1FFFFF;

    // Expected outputs of one cycle; chk=0 leaves indices unchecked (idle after done).
    typedef struct {
        logic [20:0] v;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    exp_t tl[MAXC];
    exp_t sbq[$];
    bit   st[MAXC];
    bit   ab[MAXC];
    bit   sl[MAXC];

    always #5 clk = ~clk;

    q_proj_scheduler_if #(.N_ROWS(NR), .N_TILES(NT)) bus_a ();
    q_proj_scheduler_if #(.N_ROWS(1),  .N_TILES(1))  bus_b ();

    q_proj_scheduler #(
        .N_ROWS(NR), .N_TILES(NT), .LOAD_CYCLES(LC), .DRAIN_CYCLES(DC)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    q_proj_scheduler #(
        .N_ROWS(1), .N_TILES(1), .LOAD_CYCLES(1), .DRAIN_CYCLES(1)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // {busy, w_load_en, acc_clr, x_valid, done, x_row[7:0], tile_idx[7:0]}
    function automatic logic [20:0] mk(bit b, bit wl, bit ac, bit xv, bit dn, int r, int t);
        return {b, wl, ac, xv, dn, 8'(r), 8'(t)};
    endfunction

    function automatic logic [20:0] obs_a();
        return {bus_a.busy, bus_a.w_load_en, bus_a.acc_clr, bus_a.x_valid, bus_a.done,
                8'(bus_a.x_row), 8'(bus_a.tile_idx)};
    endfunction

    function automatic logic [20:0] obs_b();
        return {bus_b.busy, bus_b.w_load_en, bus_b.acc_clr, bus_b.x_valid, bus_b.done,
                8'(bus_b.x_row), 8'(bus_b.tile_idx)};
    endfunction

    task automatic set_tl(input int c, input logic [20:0] v, input bit chk);
        if (c >= 0 && c < MAXC) begin
            tl[c].v   = v;
            tl[c].chk = chk;
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < MAXC; i++) begin
            tl[i].v   = '0;
            tl[i].chk = 1'b1;
            st[i] = 1'b0;
            ab[i] = 1'b0;
            sl[i] = 1'b0;
        end
    endtask

    // Expected trace of one job whose start is sampled in cycle t0.
    task automatic plan_job(input int t0, input int nr, input int nt, input int lc,
                            input int dc, output int done_c);
        int c;
        int r;
        c = t0 + 1;
        for (int t = 0; t < nt; t++) begin
            for (int i = 0; i < lc; i++) begin
                set_tl(c, mk(1, 1, (i == 0), 0, 0, 0, t), 1'b1);
                c++;
            end
            r = 0;
            while (r < nr && c < MAXC) begin
                if (sl[c]) begin
                    set_tl(c, mk(1, 0, 0, 0, 0, r, t), 1'b1);
                end else begin
                    set_tl(c, mk(1, 0, 0, 1, 0, r, t), 1'b1);
                    r++;
                end
                c++;
            end
            for (int i = 0; i < dc; i++) begin
                set_tl(c, mk(1, 0, 0, 0, 0, 0, t), 1'b1);
                c++;
            end
        end
        done_c = c;
        set_tl(c, mk(0, 0, 0, 0, 1, 0, 0), 1'b0);
        for (int i = c + 1; i < MAXC; i++) set_tl(i, '0, 1'b0);
    endtask

    task automatic apply_abort(input int ac);
        for (int i = ac + 1; i < MAXC; i++) set_tl(i, '0, 1'b1);
    endtask

    task automatic load_sb(input int n);
        sbq.delete();
        for (int i = 0; i < n; i++) sbq.push_back(tl[i]);
    endtask

    task automatic idle_inputs();
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.out_stall = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.out_stall = 1'b0;
    endtask

    // Advance to cycle c, drive that cycle's inputs, leave time for outputs to settle.
    task automatic tick(input int c);
        @(posedge clk);
        #1;
        bus_a.start = st[c]; bus_a.abort = ab[c]; bus_a.out_stall = sl[c];
        bus_b.start = st[c]; bus_b.abort = ab[c]; bus_b.out_stall = sl[c];
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #12;
        checks++;
        if (obs_a() !== 21'h0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", obs_a(), 21'h0);
        end
        checks++;
        if (obs_b() !== 21'h0) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", obs_b(), 21'h0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int dn, first_done;
        exp_t e;
        logic [20:0] o, m;
        clear_plan();
        plan_job(0, NR, NT, LC, DC, dn);
        st[0] = 1'b1;
        load_sb(50);
        first_done = -1;
        for (int c = 0; c < 50; c++) begin
            tick(c);
            e = sbq.pop_front();
            o = obs_a();
            m = e.chk ? ALL_M : FLAGS_M;
            checks++;
            if ((o & m) !== (e.v & m)) begin
                failures++;
                $display("FAIL nominal c=%0d got=%h exp=%h", c, o & m, e.v & m);
            end
            if (o[16] === 1'b1 && first_done < 0) first_done = c;
        end
        checks++;
        if (first_done !== 43) begin
            failures++;
            $display("FAIL nominal_done_cycle got=%0d exp=%0d", first_done, 43);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        int dn, first_done;
        exp_t e;
        logic [20:0] o, m;
        clear_plan();
        sl[3] = 1; sl[4] = 1; sl[9] = 1; sl[10] = 1; sl[16] = 1; sl[26] = 1; sl[40] = 1;
        plan_job(0, NR, NT, LC, DC, dn);
        st[0] = 1'b1;
        load_sb(50);
        first_done = -1;
        for (int c = 0; c < 50; c++) begin
            tick(c);
            e = sbq.pop_front();
            o = obs_a();
            m = e.chk ? ALL_M : FLAGS_M;
            checks++;
            if ((o & m) !== (e.v & m)) begin
                failures++;
                $display("FAIL stall c=%0d got=%h exp=%h", c, o & m, e.v & m);
            end
            if (o[16] === 1'b1 && first_done < 0) first_done = c;
        end
        checks++;
        if (first_done !== 45) begin
            failures++;
            $display("FAIL stall_done_cycle got=%0d exp=%0d", first_done, 45);
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        int dn, first_done;
        exp_t e;
        logic [20:0] o, m;
        clear_plan();
        plan_job(0, NR, NT, LC, DC, dn);
        apply_abort(9);
        plan_job(12, NR, NT, LC, DC, dn);
        st[0] = 1'b1; ab[9] = 1'b1; st[12] = 1'b1;
        load_sb(60);
        first_done = -1;
        for (int c = 0; c < 60; c++) begin
            tick(c);
            e = sbq.pop_front();
            o = obs_a();
            m = e.chk ? ALL_M : FLAGS_M;
            checks++;
            if ((o & m) !== (e.v & m)) begin
                failures++;
                $display("FAIL abort c=%0d got=%h exp=%h", c, o & m, e.v & m);
            end
            if (o[16] === 1'b1 && first_done < 0) first_done = c;
        end
        checks++;
        if (first_done !== 55) begin
            failures++;
            $display("FAIL abort_done_cycle got=%0d exp=%0d", first_done, 55);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int dn, n_done;
        exp_t e;
        logic [20:0] o, m;
        clear_plan();
        plan_job(0, NR, NT, LC, DC, dn);
        plan_job(43, NR, NT, LC, DC, dn);
        st[0] = 1; st[5] = 1; st[10] = 1; st[30] = 1; st[43] = 1;
        load_sb(92);
        n_done = 0;
        for (int c = 0; c < 92; c++) begin
            tick(c);
            e = sbq.pop_front();
            o = obs_a();
            m = e.chk ? ALL_M : FLAGS_M;
            checks++;
            if ((o & m) !== (e.v & m)) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%h exp=%h", c, o & m, e.v & m);
            end
            if (o[16] === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 2) begin
            failures++;
            $display("FAIL back_to_back_done_count got=%0d exp=%0d", n_done, 2);
        end
        idle_inputs();
    endtask

    task automatic test_start_abort_idle();
        exp_t e;
        logic [20:0] o;
        clear_plan();
        st[2] = 1'b1; ab[2] = 1'b1;
        load_sb(8);
        for (int c = 0; c < 8; c++) begin
            tick(c);
            e = sbq.pop_front();
            o = obs_a();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL start_abort_idle c=%0d got=%h exp=%h", c, o, e.v);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_drain();
        int dn, first_done;
        exp_t e;
        logic [20:0] o, m;
        clear_plan();
        plan_job(0, NR, NT, LC, DC, dn);
        st[0] = 1'b1;
        load_sb(37);
        for (int c = 0; c < 37; c++) begin
            tick(c);
            e = sbq.pop_front();
            o = obs_a();
            m = e.chk ? ALL_M : FLAGS_M;
            checks++;
            if ((o & m) !== (e.v & m)) begin
                failures++;
                $display("FAIL pre_reset c=%0d got=%h exp=%h", c, o & m, e.v & m);
            end
        end
        idle_inputs();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (obs_a() !== 21'h0) begin
            failures++;
            $display("FAIL async_reset_immediate got=%h exp=%h", obs_a(), 21'h0);
        end
        @(posedge clk);
        #2;
        checks++;
        if (obs_a() !== 21'h0) begin
            failures++;
            $display("FAIL async_reset_held got=%h exp=%h", obs_a(), 21'h0);
        end
        rst = 1'b0;
        clear_plan();
        plan_job(0, NR, NT, LC, DC, dn);
        st[0] = 1'b1;
        load_sb(46);
        first_done = -1;
        for (int c = 0; c < 46; c++) begin
            tick(c);
            e = sbq.pop_front();
            o = obs_a();
            m = e.chk ? ALL_M : FLAGS_M;
            checks++;
            if ((o & m) !== (e.v & m)) begin
                failures++;
                $display("FAIL post_reset c=%0d got=%h exp=%h", c, o & m, e.v & m);
            end
            if (o[16] === 1'b1 && first_done < 0) first_done = c;
        end
        checks++;
        if (first_done !== 43) begin
            failures++;
            $display("FAIL post_reset_done_cycle got=%0d exp=%0d", first_done, 43);
        end
        idle_inputs();
    endtask

    task automatic test_min_params();
        int dn, first_done;
        exp_t e;
        logic [20:0] o, m;
        clear_plan();
        plan_job(0, 1, 1, 1, 1, dn);
        sl[8] = 1'b1;
        plan_job(6, 1, 1, 1, 1, dn);
        st[0] = 1'b1; st[6] = 1'b1;
        load_sb(14);
        first_done = -1;
        for (int c = 0; c < 14; c++) begin
            tick(c);
            e = sbq.pop_front();
            o = obs_b();
            m = e.chk ? ALL_M : FLAGS_M;
            checks++;
            if ((o & m) !== (e.v & m)) begin
                failures++;
                $display("FAIL min_params c=%0d got=%h exp=%h", c, o & m, e.v & m);
            end
            if (o[16] === 1'b1 && first_done < 0) first_done = c;
        end
        checks++;
        if (first_done !== 4) begin
            failures++;
            $display("FAIL min_done_cycle got=%0d exp=%0d", first_done, 4);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_abort();
        test_back_to_back();
        test_start_abort_idle();
        test_reset_mid_drain();
        test_min_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
